// File: rtl/nrx_pkg.sv
// Shared timing constants for the NRX video timing generator.
// Defaults describe a 384x264 raster with a 288x224 visible window.
package nrx_pkg;

  localparam int H_TOTAL_DEF  = 384;
  localparam int V_TOTAL_DEF  = 264;
  localparam int H_ACTIVE_DEF = 288;
  localparam int V_ACTIVE_DEF = 224;

  localparam int HSYNC_START = 312;
  localparam int HSYNC_WIDTH = 32;
  localparam int VSYNC_START = 240;
  localparam int VSYNC_WIDTH = 3;

  // Sync offsets are 4-bit two's complement; widen them to window arithmetic width.
  function automatic logic [9:0] sext_ofs(input logic [3:0] ofs);
    return {{6{ofs[3]}}, ofs};
  endfunction

endpackage

// File: rtl/nrx_hvgen.sv
// Horizontal/vertical raster counter with registered blank, sync and frame outputs.
// Everything advances on a 1-in-4 pixel enable derived from CLK24M.
module nrx_hvgen
  import nrx_pkg::*;
#(
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic       CLK24M,
  input  logic       RESET_n,
  input  logic [3:0] HOFS,
  input  logic [3:0] VOFS,
  output logic       PCLK_EN,
  output logic [8:0] HP,
  output logic [8:0] VP,
  output logic       HBLK,
  output logic       VBLK,
  output logic       HSYN,
  output logic       VSYN,
  output logic       FRAME
);

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);

  logic [1:0] pre_q,  pre_d;
  logic       pclk_q, pclk_d;
  logic [8:0] hp_q,   hp_d;
  logic [8:0] vp_q,   vp_d;
  logic [3:0] hofs_q, hofs_d;
  logic [3:0] vofs_q, vofs_d;
  logic       hblk_q, hblk_d;
  logic       vblk_q, vblk_d;
  logic       hsyn_q, hsyn_d;
  logic       vsyn_q, vsyn_d;
  logic       frame_q, frame_d;

  logic       hwrap, vwrap;
  logic [9:0] hs_start, vs_start;

  // Decodes use the next counter values so blank/sync line up with HP/VP.
  always_comb begin
    pre_d   = pre_q + 2'd1;
    pclk_d  = (pre_q == 2'd3);
    hp_d    = hp_q;
    vp_d    = vp_q;
    hofs_d  = hofs_q;
    vofs_d  = vofs_q;
    hblk_d  = hblk_q;
    vblk_d  = vblk_q;
    hsyn_d  = hsyn_q;
    vsyn_d  = vsyn_q;
    frame_d = 1'b0;
    hwrap   = (hp_q == H_LAST);
    vwrap   = (vp_q == V_LAST);

    if (pclk_q) begin
      hp_d = hwrap ? '0 : hp_q + 9'd1;
      if (hwrap) begin
        vp_d = vwrap ? '0 : vp_q + 9'd1;
        if (vwrap) begin
          hofs_d = HOFS;
          vofs_d = VOFS;
        end
      end
    end

    hs_start = 10'(HSYNC_START) + sext_ofs(hofs_d);
    vs_start = 10'(VSYNC_START) + sext_ofs(vofs_d);

    if (pclk_q) begin
      hblk_d  = (hp_d >= H_ACT);
      vblk_d  = (vp_d >= V_ACT);
      hsyn_d  = ({1'b0, hp_d} >= hs_start) &&
                ({1'b0, hp_d} <  hs_start + 10'(HSYNC_WIDTH));
      if (hwrap) begin
        vsyn_d = ({1'b0, vp_d} >= vs_start) &&
                 ({1'b0, vp_d} <  vs_start + 10'(VSYNC_WIDTH));
      end
      frame_d = hwrap && (vp_d == V_ACT);
    end
  end

  always_ff @(posedge CLK24M or negedge RESET_n) begin
    if (!RESET_n) begin
      pre_q   <= '0;
      pclk_q  <= 1'b0;
      hp_q    <= '0;
      vp_q    <= '0;
      hofs_q  <= '0;
      vofs_q  <= '0;
      hblk_q  <= 1'b0;
      vblk_q  <= 1'b0;
      hsyn_q  <= 1'b0;
      vsyn_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pclk_q  <= pclk_d;
      hp_q    <= hp_d;
      vp_q    <= vp_d;
      hofs_q  <= hofs_d;
      vofs_q  <= vofs_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      hsyn_q  <= hsyn_d;
      vsyn_q  <= vsyn_d;
      frame_q <= frame_d;
    end
  end

  assign PCLK_EN = pclk_q;
  assign HP      = hp_q;
  assign VP      = vp_q;
  assign HBLK    = hblk_q;
  assign VBLK    = vblk_q;
  assign HSYN    = hsyn_q;
  assign VSYN    = vsyn_q;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_nrx_hvgen.sv
// Scoreboard bench for nrx_hvgen: a raster model predicts every CLK24M cycle's outputs,
// a monitor pops and compares; directed checks cover reset, mid-frame reset and frame spacing.
`timescale 1ns/1ps
module tb_nrx_hvgen;

  localparam int HT = 384;
  localparam int VT = 264;
  localparam int HA = 288;
  localparam int VA = 224;
  localparam int FRAME_CYC = HT * VT * 4;

  logic       clock = 1'b0;
  logic       rstN = 1'b0;
  logic [3:0] hofsIn = 4'd0;
  logic [3:0] vofsIn = 4'd0;
  logic       pclkEn, hblk, vblk, hsyn, vsyn, frame;
  logic [8:0] hp, vp;

  nrx_hvgen dut (
    .CLK24M (clock),
    .RESET_n(rstN),
    .HOFS   (hofsIn),
    .VOFS   (vofsIn),
    .PCLK_EN(pclkEn),
    .HP     (hp),
    .VP     (vp),
    .HBLK   (hblk),
    .VBLK   (vblk),
    .HSYN   (hsyn),
    .VSYN   (vsyn),
    .FRAME  (frame)
  );

  always #20 clock = ~clock;

  typedef struct packed {
    logic       pclk;
    logic [8:0] hp;
    logic [8:0] vp;
    logic       hblk;
    logic       vblk;
    logic       hsyn;
    logic       vsyn;
    logic       frame;
  } outRec_t;

  outRec_t expQ[$];
  int  checks = 0;
  int  errors = 0;
  bit  running = 1'b0;
  int  cyc = 0;
  int  curH = 0;
  int  curV = 0;
  int  frameCount = 0;
  int  lastFrameCyc = -1;
  int  firstFrameCyc = -1;
  int  frameGap = -1;

  // Cycle c after reset release shows pixel floor((c-1)/4) of a free-running raster.
  function automatic outRec_t predict(input int c, input int h, input int v);
    int pix, hpos, line, vpos;
    outRec_t r;
    pix  = (c - 1) / 4;
    hpos = pix % HT;
    line = pix / HT;
    vpos = line % VT;
    r.pclk  = (c % 4 == 0);
    r.hp    = 9'(hpos);
    r.vp    = 9'(vpos);
    r.hblk  = (hpos >= HA);
    r.vblk  = (vpos >= VA);
    r.hsyn  = (hpos >= 312 + h) && (hpos < 344 + h);
    r.vsyn  = (vpos >= 240 + v) && (vpos < 243 + v);
    r.frame = (c % 4 == 1) && (hpos == 0) && (vpos == VA);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input int atCycle, input logic [3:0] h, input logic [3:0] v);
    while (cyc < atCycle) @(negedge clock);
    hofsIn = h;
    vofsIn = v;
  endtask

  task automatic releaseReset();
    @(negedge clock);
    cyc     = 0;
    curH    = 0;
    curV    = 0;
    running = 1'b1;
    rstN    = 1'b1;
  endtask

  function automatic logic [31:0] dutOutputs();
    return 32'({pclkEn, hp, vp, hblk, vblk, hsyn, vsyn, frame});
  endfunction

  // Model: offsets seen at a frame-start edge govern the whole following frame.
  initial begin : model
    forever begin
      @(posedge clock);
      if (running) begin
        cyc = cyc + 1;
        if ((cyc % 4 == 1) && (cyc > 1) && (((cyc - 1) / 4) % (HT * VT) == 0)) begin
          curH = int'($signed(hofsIn));
          curV = int'($signed(vofsIn));
        end
        expQ.push_back(predict(cyc, curH, curV));
      end
    end
  end

  initial begin : monitor
    outRec_t e;
    forever begin
      @(negedge clock);
      if (running && expQ.size() > 0) begin
        e = expQ.pop_front();
        if (frame) begin
          frameCount = frameCount + 1;
          if (lastFrameCyc >= 0) frameGap = cyc - lastFrameCyc;
          else firstFrameCyc = cyc;
          lastFrameCyc = cyc;
        end
        if (errors < 20) checkOutput("cycleOutputs", dutOutputs(), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #60_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(negedge clock);
    checkOutput("resetState", dutOutputs(), 32'd0);

    // Run 1: run into the frame, then yank reset at VP=100/HP=200.
    releaseReset();
    applyStimulus(1000 + int'($urandom_range(0, 50000)), 4'($urandom), 4'($urandom));
    while (cyc < 4 * (100 * HT + 200) + 2) @(negedge clock);
    checkOutput("preResetPos", 32'({vp, hp}), 32'({9'd100, 9'd200}));
    #3;
    running = 1'b0;
    rstN    = 1'b0;
    #1;
    checkOutput("asyncReset", dutOutputs(), 32'd0);
    checkOutput("run1Frames", 32'(frameCount), 32'd0);
    expQ.delete();
    repeat (5) @(negedge clock);
    checkOutput("heldReset", dutOutputs(), 32'd0);
    frameCount    = 0;
    lastFrameCyc  = -1;
    firstFrameCyc = -1;
    frameGap      = -1;

    // Run 2: random offsets mid-frame, then -8/+7 for the next frame, then noise in frame 1.
    releaseReset();
    applyStimulus(20000 + int'($urandom_range(0, 100000)), 4'($urandom), 4'($urandom));
    applyStimulus(150000 + int'($urandom_range(0, 100000)), 4'($urandom), 4'($urandom));
    applyStimulus(380000, 4'b1000, 4'b0111);
    applyStimulus(420000 + int'($urandom_range(0, 80000)), 4'($urandom), 4'($urandom));
    applyStimulus(550000 + int'($urandom_range(0, 150000)), 4'($urandom), 4'($urandom));
    while (cyc < FRAME_CYC + 4 * (252 * HT) + 20) @(negedge clock);

    checkOutput("frameCount", 32'(frameCount), 32'd2);
    checkOutput("firstFrameCycle", 32'(firstFrameCyc), 32'(4 * VA * HT + 1));
    checkOutput("frameGap", 32'(frameGap), 32'(FRAME_CYC));

    running = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nrx_hvgen.md
NRX_HVGEN -- requirements
Module: nrx_hvgen

Interface
REQ-001 SHALL have parameter H_TOTAL, 384, pixels per line (HP counts 0..H_TOTAL-1).
REQ-002 SHALL have parameter V_TOTAL, 264, lines per frame (VP counts 0..V_TOTAL-1).
REQ-003 SHALL have parameter H_ACTIVE, 288, visible pixels per line.
REQ-004 SHALL have parameter V_ACTIVE, 224, visible lines; VP==V_ACTIVE is the vblank-interrupt line.
REQ-005 SHALL have port CLK24M  input  1  sole clock, 24.576MHz; all logic on its rising edge.
REQ-006 SHALL have port RESET_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port HOFS  input  4  signed horizontal sync offset, -8..+7 pixels.
REQ-008 SHALL have port VOFS  input  4  signed vertical sync offset, -8..+7 lines.
REQ-009 SHALL have port PCLK_EN  output  1  pixel enable, high one CLK24M cycle in four (6.144MHz).
REQ-010 SHALL have port HP  output  9  horizontal position to the main board.
REQ-011 SHALL have port VP  output  9  vertical position to the main board.
REQ-012 SHALL have ports HBLK, VBLK, HSYN, VSYN  output  1 each  active-high blank and sync.
REQ-013 SHALL have port FRAME  output  1  one-CLK24M pulse at start of vertical blank.

Function
REQ-014 SHALL run a free-running 2-bit prescaler; PCLK_EN SHALL be high exactly when the prescaler equals 3.
REQ-015 SHALL change HP, VP and all decoded outputs only in the cycle following a PCLK_EN-high cycle.
REQ-016 SHALL increment HP on each pixel step; at HP==H_TOTAL-1 it SHALL wrap to 0 and VP SHALL advance.
REQ-017 SHALL wrap VP from V_TOTAL-1 to 0 on the same pixel step on which HP wraps.
REQ-018 SHALL register HBLK = (HP >= H_ACTIVE) and VBLK = (VP >= V_ACTIVE), decoded from the next counter values so they align with HP/VP.
REQ-019 SHALL assert HSYN for HP in [312+hofs_l, 344+hofs_l), where hofs_l is the latched HOFS, sign-extended.
REQ-020 SHALL assert VSYN for VP in [240+vofs_l, 243+vofs_l), changing at HP==0, where vofs_l is the latched VOFS.
REQ-021 SHALL latch HOFS and VOFS into hofs_l/vofs_l only on the pixel step where HP and VP both wrap to 0; mid-frame input changes SHALL have no effect until the next frame.
REQ-022 SHALL pulse FRAME for exactly one CLK24M cycle on the pixel step where VP becomes V_ACTIVE and HP becomes 0; FRAME SHALL pulse exactly once per frame.
REQ-023 SHALL produce exactly H_TOTAL*V_TOTAL*4 = 405504 CLK24M cycles per frame (60.6Hz).
REQ-024 SHALL keep sync windows inside the blank regions for every HOFS/VOFS value (HSYN within 304..351, VSYN within 232..250); no clamping is required.

Reset
REQ-025 SHALL, while RESET_n is low, force prescaler=0, HP=0, VP=0, hofs_l=0, vofs_l=0, PCLK_EN=0, HBLK=0, VBLK=0, HSYN=0, VSYN=0, FRAME=0.
REQ-026 SHALL, after RESET_n rises, assert the first PCLK_EN on the fourth CLK24M edge and first advance HP to 1 on the following edge.
REQ-027 SHALL restart from HP=0/VP=0 when reset is asserted mid-frame, with no FRAME pulse generated by the reset itself.

Structure
REQ-028 SHALL take H_TOTAL/V_TOTAL/H_ACTIVE/V_ACTIVE defaults and sync start/width constants (312/32, 240/3) from shared package nrx_pkg.
REQ-029 SHALL be a single module with no sub-modules.

Verification
REQ-030 SHALL verify: reset release, count 16 CLK24M edges -> PCLK_EN on edges 4,8,12,16; HP 0,1,2,3.
REQ-031 SHALL verify: run one line -> HP 383 wraps to 0, VP 0->1; HBLK high exactly for HP 288..383.
REQ-032 SHALL verify: run one frame -> FRAME pulses once at VP=224/HP=0; 405504 cycles between consecutive FRAME pulses.
REQ-033 SHALL verify: HOFS=-8, VOFS=+7 applied mid-frame -> current frame HSYN 312..343, VSYN 240..242; next frame HSYN 304..335, VSYN 247..249.
REQ-034 SHALL verify: RESET_n low at VP=100/HP=200 -> all outputs 0 asynchronously; restart at HP=0/VP=0 with no spurious FRAME.
